vga_scanout: RTL
================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixel ticks.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 clk  input  1  50 MHz system clock; the block SHALL use one clock only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rd_x  output  10  framebuffer read column.
REQ-008 rd_y  output  9  framebuffer read row.
REQ-009 rd_en  output  1  framebuffer read strobe.
REQ-010 rd_data  input  1  pixel color, valid exactly one clk after rd_en.
REQ-011 VGA_R, VGA_G, VGA_B  output  8 each  pixel color.
REQ-012 VGA_HS, VGA_VS  output  1  active-low syncs.
REQ-013 VGA_BLANK_N  output  1  low outside the visible area.
REQ-014 VGA_SYNC_N  output  1  constant 0.
REQ-015 VGA_CLK  output  1  25 MHz pixel clock.
REQ-016 frame_start  output  1  one-clk pulse at pixel (0,0).

Function
REQ-017 A pix_en register SHALL toggle every clk; counters advance only on clks where pix_en=1.
REQ-018 h counter SHALL count 0..799 and wrap to 0; v SHALL increment when h wraps and itself wrap 524->0 at h=799.
REQ-019 rd_x=h and rd_y=v SHALL be driven combinationally from the counters; rd_en=1 only when pix_en=1, h<640 and v<480.
REQ-020 HS SHALL be low for h in 656..751 and VS low for v in 490..491; blank SHALL be asserted for h>=640 or v>=480.
REQ-021 On the clk after a pix_en=1 clk, VGA_R/G/B SHALL be registered as 8'hFF if the pixel is 1, otherwise 8'h00, forced to 8'h00 when blanked.
REQ-022 HS, VS and BLANK_N SHALL be delayed through the same pipeline so they align with RGB; pin latency SHALL be 2 clk from the counter value.
REQ-023 VGA_CLK SHALL be registered so that its rising edge falls mid-way through each stable output value.
REQ-024 frame_start SHALL be 1 only on the pix_en=1 clk with h=0, v=0.
REQ-025 Counter widths SHALL be 10 bits; wrap SHALL be by explicit compare, never by overflow.

Reset
REQ-026 While reset=1: h=0, v=0, pix_en=0, rd_en=0, RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_start=0.
REQ-027 On the first clk after reset release, pix_en SHALL be 1 with (h,v)=(0,0), so rd_en and frame_start are 1.
REQ-028 Reset mid-frame SHALL abandon the current frame with no partial-line output; scanning restarts per REQ-027.

Configuration
REQ-029 Macro SCANOUT_TEST_PATTERN_EN defined: add input test_mode (1 bit); when test_mode=1, pixel = h[4]^v[4] (16-pixel checkerboard) and rd_en is held 0.
REQ-030 Macro undefined: the test_mode port SHALL be absent and the pixel SHALL always be rd_data.

Verification
REQ-031 Reset, then run 2 lines -> VGA_HS low for exactly 192 clk; line period 1600 clk; HS fall 1312 clk after h=0.
REQ-032 Run 2 frames -> frame_start spacing 840000 clk; VGA_VS low for 3200 clk per frame.
REQ-033 rd_data tied 1 -> RGB=FF on visible pixels, 00 in blank; first FF appears 2 clk after rd_en for (0,0).
REQ-034 Count reads over 1 frame -> 307200 rd_en pulses; rd_x sweeps 0..639 each line; rd_y sweeps 0..479 in order.
REQ-035 Assert reset at (h,v)=(300,200) for 3 clk -> outputs take the reset values; on the first clk after release, frame_start=1 and rd_x=0, rd_y=0.
REQ-036 With SCANOUT_TEST_PATTERN_EN and test_mode=1 -> pixel (16,0)=FF, (16,16)=00, (0,0)=00; rd_en never 1.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480 VGA timing generator that fetches a 1-bit framebuffer and drives RGB/sync pins.
// Optional macro SCANOUT_TEST_PATTERN_EN adds a test_mode input selecting a 16-pixel checkerboard.

module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic       rd_data,
  output logic [9:0] rd_x,
  output logic [8:0] rd_y,
  output logic       rd_en,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       r_pix_en;
  logic       r_pix_d;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_s1_vis;
  logic       r_s1_hs_n;
  logic       r_s1_vs_n;
  logic [7:0] r_rgb;
  logic       r_hs_n;
  logic       r_vs_n;
  logic       r_blank_n;

  logic       w_visible;
  logic       w_hs_n;
  logic       w_vs_n;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_pixel;
  logic       w_rd_allow;

  assign w_visible = (r_h < H_VIS_END) && (r_v < V_VIS_END);
  assign w_hs_n    = !((r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END));
  assign w_vs_n    = !((r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END));
  assign w_h_last  = (r_h == H_LAST);
  assign w_v_last  = (r_v == V_LAST);

`ifdef SCANOUT_TEST_PATTERN_EN
  logic r_s1_tmode;
  logic r_s1_tp;

  // Test-mode select and checkerboard bit travel with the stage-1 timing flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_tmode <= 1'b0;
      r_s1_tp    <= 1'b0;
    end else if (r_pix_en) begin
      r_s1_tmode <= test_mode;
      r_s1_tp    <= r_h[4] ^ r_v[4];
    end
  end

  assign w_rd_allow = !test_mode;
  assign w_pixel    = r_s1_tmode ? r_s1_tp : rd_data;
`else
  assign w_rd_allow = 1'b1;
  assign w_pixel    = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_en  <= 1'b0;
      r_pix_d   <= 1'b0;
      r_h       <= 10'd0;
      r_v       <= 10'd0;
      r_s1_vis  <= 1'b0;
      r_s1_hs_n <= 1'b1;
      r_s1_vs_n <= 1'b1;
      r_rgb     <= 8'h00;
      r_hs_n    <= 1'b1;
      r_vs_n    <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_pix_en <= ~r_pix_en;
      r_pix_d  <= r_pix_en;
      if (r_pix_en) begin
        if (w_h_last) begin
          r_h <= 10'd0;
          r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
        r_s1_vis  <= w_visible;
        r_s1_hs_n <= w_hs_n;
        r_s1_vs_n <= w_vs_n;
      end
      // rd_data for the stage-1 pixel is valid now; update pins once per pixel.
      if (r_pix_d) begin
        r_rgb     <= (r_s1_vis && w_pixel) ? 8'hFF : 8'h00;
        r_hs_n    <= r_s1_hs_n;
        r_vs_n    <= r_s1_vs_n;
        r_blank_n <= r_s1_vis;
      end
    end
  end

  assign rd_x        = r_h;
  assign rd_y        = r_v[8:0];
  assign rd_en       = r_pix_en && w_visible && w_rd_allow;
  assign frame_start = r_pix_en && (r_h == 10'd0) && (r_v == 10'd0);

  assign VGA_R       = r_rgb;
  assign VGA_G       = r_rgb;
  assign VGA_B       = r_rgb;
  assign VGA_HS      = r_hs_n;
  assign VGA_VS      = r_vs_n;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  // Pins change when r_pix_d falls, so its rising edge lands mid-way through each pixel.
  assign VGA_CLK     = r_pix_d;

endmodule
